bounding_box_tile_traverser: RTL and testbench
==============================================

Name: bounding_box_tile_traverser

Overview:
Parametrised successor to the single-pixel bounding-box walker. It accepts a triangle bounding box, clips it to the screen, and emits every covered pixel coordinate in tile order. Tiles are TILE_W x TILE_H, aligned to the screen grid; tiles are visited row-major, and pixels within each tile are visited row-major. Output is one pixel per cycle on a valid/ready stream feeding the point sampler / fragment interpolator stage, with full backpressure, tile/last markers, and abort.

Parameters:
COORD_WIDTH, 16, width of all unsigned integer pixel coordinates
TILE_W_LOG2, 2, log2 of tile width in pixels
TILE_H_LOG2, 2, log2 of tile height in pixels
SCREEN_W, 640, screen width in pixels (must be <= 2**COORD_WIDTH - 1)
SCREEN_H, 480, screen height in pixels (same constraint)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
en  in  1  global enable; 0 freezes all state, outputs held
cmd_valid  in  1  bounding box command valid
cmd_ready  out  1  block can accept a command (high only in IDLE)
bb_l  in  COORD_WIDTH  left edge, inclusive
bb_r  in  COORD_WIDTH  right edge, exclusive
bb_t  in  COORD_WIDTH  top edge, inclusive
bb_b  in  COORD_WIDTH  bottom edge, exclusive
abort  in  1  discard the current box
pix_valid  out  1  pixel coordinate valid
pix_ready  in  1  downstream accepts the pixel
pix_x  out  COORD_WIDTH  pixel x
pix_y  out  COORD_WIDTH  pixel y
pix_tile_first  out  1  first pixel of the current tile
pix_tile_last  out  1  last pixel of the current tile
pix_last  out  1  last pixel of the box
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a box completes, including an empty box

Behaviour:
- Reset values: state=IDLE, pix_valid=0, pix_x=pix_y=0, all flags 0, done=0, busy=0, cmd_ready=1.
- en=0: no state, counter or handshake changes; cmd_ready and pix_valid are forced to 0 while en=0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & en, latch bb_* and go to SETUP.
- SETUP (1 cycle):
  - Clip: L=min(bb_l,SCREEN_W), R=min(bb_r,SCREEN_W), T=min(bb_t,SCREEN_H), B=min(bb_b,SCREEN_H).
  - If L>=R or T>=B, the box is empty: go to DONE.
  - Otherwise the tile cursor starts at tx=L with low TILE_W_LOG2 bits cleared, ty=T with low TILE_H_LOG2 bits cleared.
  - Compute the tile window: xs=max(tx,L), xe=min(tx+TILE_W,R), ys=max(ty,T), ye=min(ty+TILE_H,B).
  - Set pix=(xs,ys). Go to EMIT.
- EMIT:
  - pix_valid=1.
  - pix_x, pix_y and all flags stay stable until pix_valid & pix_ready.
  - On handshake, advance:
    - x+1 if x+1<xe;
    - else x=xs, y+1 if y+1<ye;
    - else next tile: tx+=TILE_W if tx+TILE_W<R, else tx=first tile column and ty+=TILE_H; recompute the window.
  - Exactly one pixel per handshake cycle; no bubble between tiles. Tile window calculation is combinational from the next tile cursor.
  - pix_tile_first = (x==xs && y==ys).
  - pix_tile_last = (x==xe-1 && y==ye-1).
  - pix_last = pix_tile_last && final tile (tx+TILE_W>=R && ty+TILE_H>=B).
  - A handshake with pix_last set goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency:
  - Command accepted in cycle N → first pix_valid in N+2.
  - Last handshake in cycle M → done in M+1 → cmd_ready in M+2.
- abort (en=1, state != IDLE):
  - Next cycle state=IDLE and pix_valid=0.
  - No done pulse; the current pixel is discarded.
  - This is the only case where pix_valid falls without a handshake.
  - abort in IDLE is ignored; abort with cmd_valid in IDLE accepts the command.
- Arithmetic:
  - All coordinates are unsigned.
  - tx+TILE_W is computed at COORD_WIDTH+1 bits so no wrap occurs at the top of the range.
  - A fully off-screen box (bb_l>=SCREEN_W) clips to empty.
- Async reset mid-box: immediate return to IDLE with reset values.

Decomposition:
- Package bbt_pkg: state enum (IDLE, SETUP, EMIT, DONE), TILE_W/TILE_H localparams derived from the log2 params, and the coordinate type.
- One natural sub-module, tile_window_calc: combinational; takes tile cursor and clipped box, produces xs/xe/ys/ye plus the final-tile flag.

Test Plan:
1. Defaults; box l=1 r=6 t=2 b=4, pix_ready=1 → 10 pixels in this order: (1,2)(2,2)(3,2)(1,3)(2,3)(3,3)(4,2)(5,2)(4,3)(5,3).
   - tile_first on (1,2) and (4,2); tile_last on (3,3) and (5,3); pix_last on (5,3).
   - First valid 2 cycles after accept; done 1 cycle after last.
2. Box l=5 r=5 t=0 b=8 → no pix_valid; done pulses 2 cycles after accept (SETUP→DONE).
3. Box l=636 r=700 t=478 b=500 → clipped to x 636..639, y 478..479: 8 pixels, last (639,479).
4. Scenario 1 with pix_ready toggling 1,0,0,1 → same sequence; pix_x/pix_y/flags held stable during stalls.
5. Scenario 1 with abort asserted after the 3rd handshake → pix_valid=0 next cycle, no done, cmd_ready=1; a new box then runs correctly.
6. en=0 for 3 cycles mid-EMIT with pix_ready=1 → no handshakes; sequence resumes exactly where it stopped. Async reset mid-EMIT → all outputs return to reset values immediately.

Source files
------------

// File: rtl/bounding_box_tile_traverser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bbt_pkg                                                      |
// | Description : Shared types and defaults for the bounding-box tile walker.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bbt_pkg;

    localparam int c_coord_width = 16;
    localparam int c_tile_w_log2 = 2;
    localparam int c_tile_h_log2 = 2;
    localparam int c_tile_w      = 1 << c_tile_w_log2;
    localparam int c_tile_h      = 1 << c_tile_h_log2;

    typedef logic [c_coord_width-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/bounding_box_tile_traverser_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bounding_box_tile_traverser_if                               |
// | Description : Command, pixel stream and status bundle of the tile walker.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface bounding_box_tile_traverser_if
    import bbt_pkg::*;
#(
    parameter int COORD_WIDTH = c_coord_width
) ();

    logic                   en;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [COORD_WIDTH-1:0] bb_l;
    logic [COORD_WIDTH-1:0] bb_r;
    logic [COORD_WIDTH-1:0] bb_t;
    logic [COORD_WIDTH-1:0] bb_b;
    logic                   abort;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [COORD_WIDTH-1:0] pix_x;
    logic [COORD_WIDTH-1:0] pix_y;
    logic                   pix_tile_first;
    logic                   pix_tile_last;
    logic                   pix_last;
    logic                   busy;
    logic                   done;

    modport master (
        output en, cmd_valid, bb_l, bb_r, bb_t, bb_b, abort, pix_ready,
        input  cmd_ready, pix_valid, pix_x, pix_y, pix_tile_first,
               pix_tile_last, pix_last, busy, done
    );

    modport slave (
        input  en, cmd_valid, bb_l, bb_r, bb_t, bb_b, abort, pix_ready,
        output cmd_ready, pix_valid, pix_x, pix_y, pix_tile_first,
               pix_tile_last, pix_last, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/bounding_box_tile_traverser_tile_window_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tile_window_calc                                             |
// | Description : Intersects one tile with the clipped box; flags final tile.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tile_window_calc
    import bbt_pkg::*;
#(
    parameter int COORD_WIDTH = c_coord_width,
    parameter int TILE_W_LOG2 = c_tile_w_log2,
    parameter int TILE_H_LOG2 = c_tile_h_log2
) (
    input  wire logic [COORD_WIDTH-1:0] i_tx,
    input  wire logic [COORD_WIDTH-1:0] i_ty,
    input  wire logic [COORD_WIDTH-1:0] i_l,
    input  wire logic [COORD_WIDTH-1:0] i_r,
    input  wire logic [COORD_WIDTH-1:0] i_t,
    input  wire logic [COORD_WIDTH-1:0] i_b,
    output logic      [COORD_WIDTH-1:0] o_xs,
    output logic      [COORD_WIDTH-1:0] o_xe,
    output logic      [COORD_WIDTH-1:0] o_ys,
    output logic      [COORD_WIDTH-1:0] o_ye,
    output logic                        o_last_col,
    output logic                        o_final_tile
);

    localparam logic [COORD_WIDTH:0] c_tw_ext = (COORD_WIDTH+1)'(1 << TILE_W_LOG2);
    localparam logic [COORD_WIDTH:0] c_th_ext = (COORD_WIDTH+1)'(1 << TILE_H_LOG2);

    // Tile ends carry one extra bit so a cursor near the top of the range cannot wrap.
    logic [COORD_WIDTH:0] w_tx_end;
    logic [COORD_WIDTH:0] w_ty_end;
    logic                 w_last_row;

    assign w_tx_end = {1'b0, i_tx} + c_tw_ext;
    assign w_ty_end = {1'b0, i_ty} + c_th_ext;

    assign o_xs = (i_tx > i_l) ? i_tx : i_l;
    assign o_ys = (i_ty > i_t) ? i_ty : i_t;
    assign o_xe = (w_tx_end < {1'b0, i_r}) ? w_tx_end[COORD_WIDTH-1:0] : i_r;
    assign o_ye = (w_ty_end < {1'b0, i_b}) ? w_ty_end[COORD_WIDTH-1:0] : i_b;

    assign o_last_col   = (w_tx_end >= {1'b0, i_r});
    assign w_last_row   = (w_ty_end >= {1'b0, i_b});
    assign o_final_tile = o_last_col && w_last_row;

endmodule
`default_nettype wire

// File: rtl/bounding_box_tile_traverser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bounding_box_tile_traverser                                  |
// | Description : Clips a bounding box and streams its pixels in tile order.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bounding_box_tile_traverser
    import bbt_pkg::*;
#(
    parameter int COORD_WIDTH = c_coord_width,
    parameter int TILE_W_LOG2 = c_tile_w_log2,
    parameter int TILE_H_LOG2 = c_tile_h_log2,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    bounding_box_tile_traverser_if.slave bus
);

    localparam logic [COORD_WIDTH-1:0] c_tw       = COORD_WIDTH'(1 << TILE_W_LOG2);
    localparam logic [COORD_WIDTH-1:0] c_th       = COORD_WIDTH'(1 << TILE_H_LOG2);
    localparam logic [COORD_WIDTH-1:0] c_screen_w = COORD_WIDTH'(SCREEN_W);
    localparam logic [COORD_WIDTH-1:0] c_screen_h = COORD_WIDTH'(SCREEN_H);

    state_e r_state;
    state_e w_state_next;

    logic [COORD_WIDTH-1:0] r_bb_l, r_bb_r, r_bb_t, r_bb_b;
    logic [COORD_WIDTH-1:0] r_tx, r_ty;
    logic [COORD_WIDTH-1:0] r_xs, r_xe, r_ys, r_ye;
    logic [COORD_WIDTH-1:0] r_x, r_y;
    logic                   r_last_col;
    logic                   r_final;

    logic [COORD_WIDTH-1:0] w_clip_l, w_clip_r, w_clip_t, w_clip_b;
    logic [COORD_WIDTH-1:0] w_first_tx, w_first_ty;
    logic [COORD_WIDTH-1:0] w_ntx, w_nty;
    logic [COORD_WIDTH-1:0] w_xs, w_xe, w_ys, w_ye;
    logic                   w_last_col, w_final;
    logic                   w_empty;
    logic                   w_emit, w_hs;
    logic [COORD_WIDTH:0]   w_x_inc, w_y_inc;
    logic                   w_x_at_end, w_y_at_end;
    logic                   w_tile_first, w_tile_last, w_pix_last;

    assign w_clip_l = (r_bb_l < c_screen_w) ? r_bb_l : c_screen_w;
    assign w_clip_r = (r_bb_r < c_screen_w) ? r_bb_r : c_screen_w;
    assign w_clip_t = (r_bb_t < c_screen_h) ? r_bb_t : c_screen_h;
    assign w_clip_b = (r_bb_b < c_screen_h) ? r_bb_b : c_screen_h;
    assign w_empty  = (w_clip_l >= w_clip_r) || (w_clip_t >= w_clip_b);

    assign w_first_tx = w_clip_l & ~(c_tw - 1'b1);
    assign w_first_ty = w_clip_t & ~(c_th - 1'b1);

    assign w_emit       = (r_state == EMIT);
    assign w_hs         = bus.en && w_emit && bus.pix_ready;
    assign w_x_inc      = {1'b0, r_x} + 1'b1;
    assign w_y_inc      = {1'b0, r_y} + 1'b1;
    assign w_x_at_end   = (w_x_inc == {1'b0, r_xe});
    assign w_y_at_end   = (w_y_inc == {1'b0, r_ye});
    assign w_tile_first = (r_x == r_xs) && (r_y == r_ys);
    assign w_tile_last  = w_x_at_end && w_y_at_end;
    assign w_pix_last   = w_tile_last && r_final;

    // The window unit always looks at the tile the cursor will move to next,
    // so a tile change lands in the same cycle as the handshake.
    always_comb begin
        w_ntx = w_tx_next_col_or_first();
        w_nty = r_ty;
        if (r_state == SETUP) begin
            w_ntx = w_first_tx;
            w_nty = w_first_ty;
        end else if (r_last_col) begin
            w_nty = r_ty + c_th;
        end
    end

    function automatic logic [COORD_WIDTH-1:0] w_tx_next_col_or_first();
        return r_last_col ? w_first_tx : (r_tx + c_tw);
    endfunction

    tile_window_calc #(
        .COORD_WIDTH (COORD_WIDTH),
        .TILE_W_LOG2 (TILE_W_LOG2),
        .TILE_H_LOG2 (TILE_H_LOG2)
    ) u_tile_window_calc (
        .i_tx         (w_ntx),
        .i_ty         (w_nty),
        .i_l          (w_clip_l),
        .i_r          (w_clip_r),
        .i_t          (w_clip_t),
        .i_b          (w_clip_b),
        .o_xs         (w_xs),
        .o_xe         (w_xe),
        .o_ys         (w_ys),
        .o_ye         (w_ye),
        .o_last_col   (w_last_col),
        .o_final_tile (w_final)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.en) begin
            if (bus.abort && (r_state != IDLE)) begin
                w_state_next = IDLE;
            end else begin
                case (r_state)
                    IDLE:    if (bus.cmd_valid) w_state_next = SETUP;
                    SETUP:   w_state_next = w_empty ? DONE : EMIT;
                    EMIT:    if (bus.pix_ready && w_pix_last) w_state_next = DONE;
                    DONE:    w_state_next = IDLE;
                    default: w_state_next = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bb_l     <= '0;
            r_bb_r     <= '0;
            r_bb_t     <= '0;
            r_bb_b     <= '0;
            r_tx       <= '0;
            r_ty       <= '0;
            r_xs       <= '0;
            r_xe       <= '0;
            r_ys       <= '0;
            r_ye       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_last_col <= 1'b0;
            r_final    <= 1'b0;
        end else if (bus.en) begin
            if ((r_state == IDLE) && bus.cmd_valid) begin
                r_bb_l <= bus.bb_l;
                r_bb_r <= bus.bb_r;
                r_bb_t <= bus.bb_t;
                r_bb_b <= bus.bb_b;
            end
            if (((r_state == SETUP) && !w_empty) || (w_hs && w_tile_last && !r_final)) begin
                r_tx       <= w_ntx;
                r_ty       <= w_nty;
                r_xs       <= w_xs;
                r_xe       <= w_xe;
                r_ys       <= w_ys;
                r_ye       <= w_ye;
                r_last_col <= w_last_col;
                r_final    <= w_final;
                r_x        <= w_xs;
                r_y        <= w_ys;
            end else if (w_hs && !w_pix_last) begin
                if (!w_x_at_end) begin
                    r_x <= w_x_inc[COORD_WIDTH-1:0];
                end else begin
                    r_x <= r_xs;
                    r_y <= w_y_inc[COORD_WIDTH-1:0];
                end
            end
        end
    end

    assign bus.cmd_ready      = bus.en && (r_state == IDLE);
    assign bus.pix_valid      = bus.en && w_emit;
    assign bus.pix_x          = r_x;
    assign bus.pix_y          = r_y;
    assign bus.pix_tile_first = w_emit && w_tile_first;
    assign bus.pix_tile_last  = w_emit && w_tile_last;
    assign bus.pix_last       = w_emit && w_pix_last;
    assign bus.busy           = (r_state != IDLE);
    assign bus.done           = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_bounding_box_tile_traverser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bounding_box_tile_traverser                               |
// | Description : Directed scoreboard bench for the bounding-box tile walker.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bounding_box_tile_traverser;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        tf;
        logic        tl;
        logic        last;
    } pix_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    pix_t q[$];
    pix_t held;
    logic hold_v        = 1'b0;
    logic first_pending = 1'b0;
    int   acc_cyc = 0, first_cyc = 0, done_cyc = 0, last_cyc = 0;
    int   done_cnt = 0, hs_cnt = 0, valid_cnt = 0;
    int   last_x = 0, last_y = 0;

    int s1x [10] = '{1, 2, 3, 1, 2, 3, 4, 5, 4, 5};
    int s1y [10] = '{2, 2, 2, 3, 3, 3, 2, 2, 3, 3};
    logic rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    bounding_box_tile_traverser_if #(.COORD_WIDTH(16)) bus ();

    bounding_box_tile_traverser #(
        .COORD_WIDTH (16),
        .TILE_W_LOG2 (2),
        .TILE_H_LOG2 (2),
        .SCREEN_W    (640),
        .SCREEN_H    (480)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        pix_t e;
        if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
        if (bus.pix_valid) begin
            valid_cnt++;
            if (first_pending) begin
                first_cyc     = cyc;
                first_pending = 1'b0;
            end
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (hold_v && bus.pix_valid) begin
            check("stall_x", bus.pix_x, held.x);
            check("stall_y", bus.pix_y, held.y);
            check("stall_flags", {bus.pix_tile_first, bus.pix_tile_last, bus.pix_last},
                  {held.tf, held.tl, held.last});
        end
        if (bus.pix_valid && bus.pix_ready) begin
            hs_cnt++;
            if (q.size() == 0) begin
                check("sb_underflow", q.size(), 1);
            end else begin
                e = q.pop_front();
                check("pix_x", bus.pix_x, e.x);
                check("pix_y", bus.pix_y, e.y);
                check("tile_first", bus.pix_tile_first, e.tf);
                check("tile_last", bus.pix_tile_last, e.tl);
                check("pix_last", bus.pix_last, e.last);
            end
            if (bus.pix_last) begin
                last_cyc = cyc;
                last_x   = bus.pix_x;
                last_y   = bus.pix_y;
            end
        end
        hold_v = bus.pix_valid && !bus.pix_ready;
        held   = '{bus.pix_x, bus.pix_y, bus.pix_tile_first, bus.pix_tile_last, bus.pix_last};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_s1();
        for (int i = 0; i < 10; i++)
            q.push_back('{16'(s1x[i]), 16'(s1y[i]), (i == 0 || i == 6), (i == 5 || i == 9), (i == 9)});
    endtask

    // Reference order: nested loops over aligned 4x4 tiles, then pixels inside each tile.
    task automatic push_model(input int l, input int r, input int t, input int b);
        int cl, cr, ct, cb, xs, xe, ys, ye;
        cl = (l < 640) ? l : 640;
        cr = (r < 640) ? r : 640;
        ct = (t < 480) ? t : 480;
        cb = (b < 480) ? b : 480;
        if (cl >= cr || ct >= cb) return;
        for (int ty = ct & ~3; ty < cb; ty += 4) begin
            for (int tx = cl & ~3; tx < cr; tx += 4) begin
                xs = (tx > cl) ? tx : cl;
                xe = (tx + 4 < cr) ? tx + 4 : cr;
                ys = (ty > ct) ? ty : ct;
                ye = (ty + 4 < cb) ? ty + 4 : cb;
                for (int y = ys; y < ye; y++)
                    for (int x = xs; x < xe; x++)
                        q.push_back('{16'(x), 16'(y), (x == xs && y == ys),
                                      (x == xe - 1 && y == ye - 1),
                                      (x == xe - 1 && y == ye - 1 && tx + 4 >= cr && ty + 4 >= cb)});
            end
        end
    endtask

    task automatic send_box(input int l, input int r, input int t, input int b);
        logic ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("cmd_ready_wait", ok, 1);
        bus.bb_l = 16'(l);
        bus.bb_r = 16'(r);
        bus.bb_t = 16'(t);
        bus.bb_b = 16'(b);
        bus.cmd_valid = 1'b1;
        first_pending = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic toggle_ready);
        int   base = done_cnt;
        logic ok   = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (toggle_ready) bus.pix_ready = rdy_pat[i % 4];
            tick();
            if (done_cnt != base) begin
                ok = 1'b1;
                break;
            end
        end
        bus.pix_ready = 1'b1;
        check(tag, ok, 1);
    endtask

    task automatic wait_hs(input int n);
        int   base = hs_cnt;
        logic ok   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (hs_cnt >= base + n) begin
                ok = 1'b1;
                break;
            end
        end
        check("hs_wait", ok, 1);
    endtask

    initial begin
        int base_hs, base_done, base_valid;
        bus.en = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.abort = 1'b0;
        bus.pix_ready = 1'b1;
        bus.bb_l = '0;
        bus.bb_r = '0;
        bus.bb_t = '0;
        bus.bb_b = '0;

        #3;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_pix_valid", bus.pix_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_pix_xy", {bus.pix_x, bus.pix_y}, 0);
        check("rst_flags", {bus.pix_tile_first, bus.pix_tile_last, bus.pix_last}, 0);
        tick();
        reset = 1'b0;
        tick();

        // Two-tile box with full throughput
        push_s1();
        base_hs = hs_cnt;
        send_box(1, 6, 2, 4);
        wait_done("s1_done", 1'b0);
        check("s1_first_latency", first_cyc - acc_cyc, 2);
        check("s1_done_latency", done_cyc - last_cyc, 1);
        check("s1_cmd_ready_after", bus.cmd_ready, 1);
        check("s1_hs_count", hs_cnt - base_hs, 10);
        check("s1_sb_empty", q.size(), 0);

        // Empty box: SETUP straight to DONE
        base_valid = valid_cnt;
        send_box(5, 5, 0, 8);
        wait_done("s2_done", 1'b0);
        check("s2_no_valid", valid_cnt - base_valid, 0);
        check("s2_done_latency", done_cyc - acc_cyc, 2);

        // Box clipped at the bottom-right screen corner
        push_model(636, 700, 478, 500);
        base_hs = hs_cnt;
        send_box(636, 700, 478, 500);
        wait_done("s3_done", 1'b0);
        check("s3_hs_count", hs_cnt - base_hs, 8);
        check("s3_last_xy", {16'(last_x), 16'(last_y)}, {16'd639, 16'd479});
        check("s3_sb_empty", q.size(), 0);

        // Multi-row tile grid
        push_model(3, 10, 1, 7);
        send_box(3, 10, 1, 7);
        wait_done("s3b_done", 1'b0);
        check("s3b_sb_empty", q.size(), 0);

        // Backpressure pattern 1,0,0,1
        push_s1();
        send_box(1, 6, 2, 4);
        wait_done("s4_done", 1'b1);
        check("s4_sb_empty", q.size(), 0);

        // Abort after the third handshake
        push_s1();
        base_hs   = hs_cnt;
        base_done = done_cnt;
        send_box(1, 6, 2, 4);
        wait_hs(3);
        bus.pix_ready = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.pix_ready = 1'b1;
        check("s5_valid_low", bus.pix_valid, 0);
        check("s5_cmd_ready", bus.cmd_ready, 1);
        check("s5_hs_count", hs_cnt - base_hs, 3);
        q.delete();
        tick();
        tick();
        check("s5_no_done", done_cnt - base_done, 0);
        push_s1();
        send_box(1, 6, 2, 4);
        wait_done("s5_rerun_done", 1'b0);
        check("s5_rerun_sb_empty", q.size(), 0);

        // Enable freeze mid-EMIT
        push_s1();
        base_hs = hs_cnt;
        send_box(1, 6, 2, 4);
        wait_hs(4);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s6_frozen_valid", bus.pix_valid, 0);
            check("s6_frozen_cmd_ready", bus.cmd_ready, 0);
            check("s6_frozen_busy", bus.busy, 1);
        end
        check("s6_frozen_hs", hs_cnt - base_hs, 4);
        bus.en = 1'b1;
        wait_done("s6_done", 1'b0);
        check("s6_sb_empty", q.size(), 0);

        // Asynchronous reset mid-EMIT
        push_s1();
        base_done = done_cnt;
        send_box(1, 6, 2, 4);
        wait_hs(3);
        #2;
        reset = 1'b1;
        #1;
        check("s6r_pix_valid", bus.pix_valid, 0);
        check("s6r_cmd_ready", bus.cmd_ready, 1);
        check("s6r_busy", bus.busy, 0);
        check("s6r_pix_xy", {bus.pix_x, bus.pix_y}, 0);
        check("s6r_flags", {bus.pix_tile_first, bus.pix_tile_last, bus.pix_last, bus.done}, 0);
        tick();
        reset = 1'b0;
        q.delete();
        tick();
        check("s6r_no_done", done_cnt - base_done, 0);
        push_model(3, 10, 1, 7);
        send_box(3, 10, 1, 7);
        wait_done("s6r_rerun_done", 1'b0);
        check("s6r_rerun_sb_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
